// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit arbiter.
// Frame timing constants describe the 8N1 link the arbiter feeds.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam int CLOCK_RATE = 100_000_000;
  localparam int BAUD_RATE = 9600;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first set bit scanning from i_ptr.
// Ports: i_req request vector, i_ptr start index, o_found, o_idx winner.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int GID_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GID_W-1:0] i_ptr,
  output logic             o_found,
  output logic [GID_W-1:0] o_idx
);

  always_comb begin
    int j;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!o_found && i_req[j]) begin
        o_found = 1'b1;
        o_idx   = GID_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter among
// N_REQ requesters; multi-byte messages hold the grant until last.
// Ports: clk, rst (async high); req_valid/req_data/req_last in,
// req_ready out; tx_start/tx_data out, tx_busy in; grant_id, locked,
// timeout_flag status. Define UART_ARB_TIMEOUT_EN for the lock watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int GID_W = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [GID_W-1:0]        grant_id,
  output logic                    locked,
  output logic                    timeout_flag
);

  state_t             r_state, w_state_n;
  logic [GID_W-1:0]   r_ptr, w_ptr_n;
  logic [GID_W-1:0]   r_gid, w_gid_n;
  logic               r_lock, w_lock_n;
  logic               r_start, w_start_n;
  logic [BYTE_W-1:0]  r_data, w_data_n;
  logic [N_REQ-1:0]   r_ready, w_ready_n;

  logic               w_rr_found;
  logic [GID_W-1:0]   w_rr_idx;
  logic               w_hold_v;
  logic               w_found;
  logic [GID_W-1:0]   w_win;
  logic               w_to_fire;

  function automatic logic [GID_W-1:0] f_inc(input logic [GID_W-1:0] v);
    f_inc = (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  rr_pick #(
    .N_REQ (N_REQ),
    .GID_W (GID_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_rr_found),
    .o_idx   (w_rr_idx)
  );

  // While locked only the holder may be picked.
  assign w_hold_v = req_valid[r_gid];
  assign w_found  = r_lock ? w_hold_v : w_rr_found;
  assign w_win    = r_lock ? r_gid : w_rr_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_to_flag;
  logic             w_cnt_en;

  assign w_cnt_en  = r_lock && (r_state == IDLE) && !w_hold_v;
  assign w_to_fire = w_cnt_en && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_to_flag <= 1'b0;
    end else begin
      if (r_state == SEND || w_to_fire) r_cnt <= '0;
      else if (w_cnt_en) r_cnt <= r_cnt + 1'b1;
      if (w_to_fire) r_to_flag <= 1'b1;
    end
  end

  assign timeout_flag = r_to_flag;
`else
  assign w_to_fire    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_gid_n   = r_gid;
    w_lock_n  = r_lock;
    w_start_n = 1'b0;
    w_data_n  = r_data;
    w_ready_n = '0;
    unique case (r_state)
      IDLE: begin
        if (w_to_fire) begin
          w_lock_n = 1'b0;
          w_ptr_n  = f_inc(r_gid);
        end else if (!tx_busy && w_found) begin
          // Outputs are registered, so SEND values load on this edge.
          w_state_n = SEND;
          w_gid_n   = w_win;
          w_start_n = 1'b1;
          w_data_n  = req_data[int'(w_win)*BYTE_W +: BYTE_W];
          w_ready_n = N_REQ'(1) << w_win;
          w_lock_n  = !req_last[w_win];
          if (req_last[w_win]) w_ptr_n = f_inc(w_win);
        end
      end
      SEND:    w_state_n = WAIT_HI;
      WAIT_HI: if (tx_busy) w_state_n = WAIT_LO;
      WAIT_LO: if (!tx_busy) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_lock  <= 1'b0;
      r_start <= 1'b0;
      r_data  <= '0;
      r_ready <= '0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_gid   <= w_gid_n;
      r_lock  <= w_lock_n;
      r_start <= w_start_n;
      r_data  <= w_data_n;
      r_ready <= w_ready_n;
    end
  end

  assign req_ready = r_ready;
  assign tx_start  = r_start;
  assign tx_data   = r_data;
  assign grant_id  = r_gid;
  assign locked    = r_lock;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short-frame tx_busy model.
// Build with UART_ARB_TIMEOUT_EN to exercise the lock watchdog.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N     = 3;
  localparam int GW    = 2;
  localparam int TO    = 100;
  localparam int FRAME = 30;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [GW-1:0]  grant_id;
  logic           locked;
  logic           timeout_flag;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .GID_W          (GW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .locked       (locked),
    .timeout_flag (timeout_flag)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int err    = 0;

  logic [7:0]  lg_data[$];
  logic [GW-1:0] lg_gid[$];
  int          lg_cyc[$];
  bit          lg_lock[$];

  logic [8:0] rq[N][$];
  bit         pend[N];
  bit         flush = 1'b0;
  bit         model_en = 1'b1;
  bit         force_busy = 1'b0;
  int         bdly = 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(int i, logic [7:0] b, bit last);
    rq[i].push_back({last, b});
  endtask

  task automatic wait_n(int n, int budget);
    int k = 0;
    while (lg_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_start", 32'(lg_data.size() >= n), 1);
  endtask

  // Monitor: start log and protocol watch.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
        lg_data.push_back(tx_data);
        lg_gid.push_back(grant_id);
        lg_cyc.push_back(cyc);
        lg_lock.push_back(locked);
      end
      if ($countones(req_ready) > 1) err++;
      if ((req_ready & ~req_valid) != '0) err++;
    end
  end

  // Requesters: present queue head, pop one cycle after the accept.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (flush) begin
          rq[i].delete();
          req_valid[i] = 1'b0;
          pend[i] = 1'b0;
        end else begin
          if (pend[i]) begin
            void'(rq[i].pop_front());
            req_valid[i] = 1'b0;
            pend[i] = 1'b0;
          end
          if (!req_valid[i] && rq[i].size() > 0) begin
            req_valid[i] = 1'b1;
            req_data[i*8 +: 8] = rq[i][0][7:0];
            req_last[i] = rq[i][0][8];
          end
          pend[i] = req_valid[i] && req_ready[i];
        end
      end
    end
  end

  // Transmitter: busy rises bdly cycles after start, lasts FRAME cycles.
  initial begin
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!model_en) begin
        tx_busy = force_busy;
        ph = 0;
      end else begin
        case (ph)
          0: if (tx_start) begin
            cnt = bdly;
            ph = 1;
          end
          1: begin
            cnt--;
            if (cnt == 0) begin
              tx_busy = 1'b1;
              cnt = FRAME;
              ph = 2;
            end
          end
          default: begin
            cnt--;
            if (cnt == 0) begin
              tx_busy = 1'b0;
              ph = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b;
    int c0;
    int c1;
    int k;
    logic [7:0] e3[5];
    e3 = '{"1", "1", "2", "3", ASCII_CR};

    rst = 1'b1;
    tick(3);
    chk("rst_outs", {tx_start, tx_data, req_ready, grant_id,
                     locked, timeout_flag}, 0);
    rst = 1'b0;
    tick(2);

    // single-byte message, latency
    push(0, "1", 1'b1);
    k = 0;
    while (!req_valid[0] && k < 5) begin tick(); k++; end
    c0 = cyc;
    k = 0;
    while (!tx_start && k < 5) begin tick(); k++; end
    c1 = cyc;
    chk("t1_latency", c1 - c0, 1);
    chk("t1_data", tx_data, 8'h31);
    chk("t1_ready", req_ready, 3'b001);
    chk("t1_locked", locked, 0);
    tick();
    chk("t1_ready_off", {tx_start, req_ready}, 0);
    chk("t1_ptr", dut.r_ptr, 1);
    tick(FRAME + 8);

    // three simultaneous single bytes, ptr=1
    b = lg_data.size();
    push(0, "A", 1'b1);
    push(1, "B", 1'b1);
    push(2, "C", 1'b1);
    wait_n(b + 3, 3 * (FRAME + 10));
    chk("t2_order", {lg_data[b], lg_data[b+1], lg_data[b+2]},
        {"B", "C", "A"});
    chk("t2_gid", {lg_gid[b], lg_gid[b+1], lg_gid[b+2]}, 6'b01_10_00);
    chk("t2_gap1", lg_cyc[b+1] - lg_cyc[b], FRAME + 3);
    chk("t2_gap2", lg_cyc[b+2] - lg_cyc[b+1], FRAME + 3);
    tick(FRAME + 8);

    // message "1123\r" is not interleaved with req1's "X"
    b = lg_data.size();
    push(0, "1", 1'b0);
    push(0, "1", 1'b0);
    push(0, "2", 1'b0);
    push(0, "3", 1'b0);
    push(0, ASCII_CR, 1'b1);
    wait_n(b + 1, 10);
    push(1, "X", 1'b1);
    wait_n(b + 6, 6 * (FRAME + 10));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_byte%0d", i), lg_data[b+i], e3[i]);
      chk($sformatf("t3_lock%0d", i), lg_lock[b+i], (i < 4) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_gap%0d", i), lg_cyc[b+i+1] - lg_cyc[b+i],
          FRAME + 3);
    chk("t3_x", {lg_data[b+5], lg_gid[b+5]}, {"X", 2'd1});
    tick(FRAME + 8);

    // reset in the middle of a message with the transmitter busy
    b = lg_data.size();
    push(0, "a", 1'b0);
    push(0, "b", 1'b0);
    push(0, "c", 1'b1);
    wait_n(b + 2, 2 * (FRAME + 10));
    tick(3);
    chk("t4_pre_lock", locked, 1);
    model_en = 1'b0;
    force_busy = 1'b1;
    flush = 1'b1;
    rst = 1'b1;
    #1;
    chk("t4_rst_outs", {tx_start, tx_data, req_ready, grant_id,
                        locked, timeout_flag}, 0);
    tick();
    flush = 1'b0;
    tick(2);
    rst = 1'b0;
    push(1, "Y", 1'b1);
    tick(10);
    chk("t4_busy_hold", lg_data.size(), b + 2);
    chk("t4_unlocked", locked, 0);
    force_busy = 1'b0;
    tick();
    model_en = 1'b1;
    wait_n(b + 3, 20);
    chk("t4_y", {lg_data[b+2], lg_gid[b+2]}, {"Y", 2'd1});
    tick(FRAME + 8);

    // slow busy rise: no early restart
    bdly = 2;
    b = lg_data.size();
    push(2, "P", 1'b1);
    push(2, "Q", 1'b1);
    wait_n(b + 2, 2 * (FRAME + 12));
    chk("t5_data", {lg_data[b], lg_data[b+1]}, {"P", "Q"});
    chk("t5_gap", lg_cyc[b+1] - lg_cyc[b], FRAME + 4);
    bdly = 1;
    tick(FRAME + 8);

    // holder goes quiet while locked
    b = lg_data.size();
    push(0, "T", 1'b0);
    wait_n(b + 1, 10);
    push(1, "U", 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    tick(FRAME + 10);
    chk("t6_lock_held", {locked, timeout_flag}, 2'b10);
    wait_n(b + 2, TO + FRAME + 40);
    chk("t6_u", {lg_data[b+1], lg_gid[b+1]}, {"U", 2'd1});
    chk("t6_gap", lg_cyc[b+1] - lg_cyc[b], FRAME + TO + 3);
    chk("t6_flag", {locked, timeout_flag}, 2'b01);
    tick(FRAME + 8);
    chk("t6_sticky", timeout_flag, 1);
`else
    tick(FRAME + TO + 60);
    chk("t6_no_u", lg_data.size(), b + 1);
    chk("t6_lock_held", {locked, timeout_flag}, 2'b10);
    push(0, "V", 1'b1);
    wait_n(b + 3, 2 * (FRAME + 10));
    chk("t6_order", {lg_data[b+1], lg_data[b+2]}, {"V", "U"});
`endif
    tick(FRAME + 8);

    chk("protocol", err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
